id_ex_stage: RTL and testbench

ID/EX pipeline register for the 5-stage pipelined LEGv8 CPU, with load-use hazard detection, branch flush and memory-wait freeze. It captures decoded instruction fields each cycle and presents them to the execute stage: ALU control unit, ALU and flag logic. It inserts a one-cycle bubble on a load-use hazard and stalls PC and IF/ID while it does so. It keeps a saturating count of bubbles inserted.

---
 rtl/cpu_pkg.sv | 60 ++++++
 rtl/id_ex_stage_hazard_detect.sv | 31 +++
 rtl/id_ex_stage.sv | 154 +++++++++++++++
 tb/tb_id_ex_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the LEGv8 pipeline: opcodes, the ID/EX record, and update-source selector.
// Latency: none; this package holds only types, constants and pure functions.
// Backpressure: none; nothing here carries state.
package cpu_pkg;

    // Width of the data fields held in the ID/EX record.
    localparam int XLEN = 64;

    // Full 11-bit opcodes, taken from instruction[31:21].
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;

    // Short-format opcodes are matched on a prefix of instruction[31:21].
    localparam logic [9:0] OP_ADDI_PFX  = 10'b1001000100;
    localparam logic [7:0] OP_CBZ_PFX   = 8'b10110100;
    localparam logic [7:0] OP_BCOND_PFX = 8'b01010100;
    localparam logic [5:0] OP_BL_PFX    = 6'b100101;

    // X31 as a destination discards the result, so it never carries a dependence.
    localparam logic [4:0] XZR = 5'd31;

    // Everything the execute stage needs from decode, captured in one register.
    typedef struct packed {
        logic            valid;
        logic [10:0]     opcode;
        logic            alu_on;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            set_flags;
        logic [4:0]      rn;
        logic [4:0]      rm;
        logic [4:0]      rd;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
    } id_ex_t;

    // Source of the next ID/EX contents, highest priority first.
    typedef enum logic [2:0] {
        UPD_FLUSH,    // branch kill: bubble
        UPD_HOLD,     // data memory busy: keep current contents
        UPD_HAZARD,   // load-use: bubble, counted
        UPD_CAPTURE,  // normal advance of a valid ID instruction
        UPD_IDLE      // ID empty: bubble, not counted
    } upd_sel_e;

    // A bubble is the all-zero record: invalid, no controls, ALU off.
    function automatic id_ex_t bubble();
        bubble = '0;
    endfunction

    // True for the one opcode whose result is only available after memory.
    function automatic logic is_load(input logic [10:0] opcode);
        is_load = (opcode == OP_LDUR);
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: EX holds a load whose destination ID is about to read.
// Latency: purely combinational, same cycle.
// Backpressure: none; the stage above decides how flush and mem_busy override it.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_reg_write_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rn_i,
    input  logic [4:0] id_rm_i,
    input  logic       id_rn_used_i,
    input  logic       id_rm_used_i,
    output logic       haz_o
);

    logic ex_load_writes;
    logic rn_dep;
    logic rm_dep;

    // A load in EX only blocks ID when it really writes a register other than XZR.
    always_comb begin
        ex_load_writes = ex_valid_i & ex_mem_read_i & ex_reg_write_i & (ex_rd_i != XZR);
        rn_dep         = id_rn_used_i & (id_rn_i == ex_rd_i);
        rm_dep         = id_rm_used_i & (id_rm_i == ex_rd_i);
        haz_o          = ex_load_writes & id_valid_i & (rn_dep | rm_dep);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and memory-wait freeze.
// Latency: one cycle from ID capture to ex_* outputs; a load-use hazard costs one extra bubble cycle.
// Backpressure: mem_busy freezes ex_*; stall asks PC and IF/ID to hold only while a load-use bubble goes in.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              id_valid,
    input  logic [10:0]       id_opcode,
    input  logic              id_alu_on,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_reg_write,
    input  logic              id_set_flags,
    input  logic [4:0]        id_rn,
    input  logic [4:0]        id_rm,
    input  logic [4:0]        id_rd,
    input  logic              id_rn_used,
    input  logic              id_rm_used,
    input  logic [DATA_W-1:0] id_a,
    input  logic [DATA_W-1:0] id_b,
    input  logic [DATA_W-1:0] id_imm,

    input  logic              flush,
    input  logic              mem_busy,

    output logic              ex_valid,
    output logic              ex_alu_on,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic              ex_set_flags,
    output logic [10:0]       ex_opcode,
    output logic [4:0]        ex_rn,
    output logic [4:0]        ex_rm,
    output logic [4:0]        ex_rd,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,

    output logic              stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    id_ex_t           ex_q;
    id_ex_t           ex_d;
    id_ex_t           id_rec;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             haz;
    upd_sel_e         upd_sel;

    hazard_detect u_hazard_detect (
        .ex_valid_i     (ex_q.valid),
        .ex_mem_read_i  (ex_q.mem_read),
        .ex_reg_write_i (ex_q.reg_write),
        .ex_rd_i        (ex_q.rd),
        .id_valid_i     (id_valid),
        .id_rn_i        (id_rn),
        .id_rm_i        (id_rm),
        .id_rn_used_i   (id_rn_used),
        .id_rm_used_i   (id_rm_used),
        .haz_o          (haz)
    );

    // Pack the decoded ID fields into one record, ready to be captured.
    always_comb begin
        id_rec           = '0;
        id_rec.valid     = 1'b1;
        id_rec.opcode    = id_opcode;
        id_rec.alu_on    = id_alu_on;
        id_rec.mem_read  = id_mem_read;
        id_rec.mem_write = id_mem_write;
        id_rec.reg_write = id_reg_write;
        id_rec.set_flags = id_set_flags;
        id_rec.rn        = id_rn;
        id_rec.rm        = id_rm;
        id_rec.rd        = id_rd;
        id_rec.a         = id_a;
        id_rec.b         = id_b;
        id_rec.imm       = id_imm;
    end

    // Choose this cycle's update; flush beats the freeze, the freeze beats the hazard.
    always_comb begin
        upd_sel = UPD_IDLE;
        if (flush) begin
            upd_sel = UPD_FLUSH;
        end else if (mem_busy) begin
            upd_sel = UPD_HOLD;
        end else if (haz) begin
            upd_sel = UPD_HAZARD;
        end else if (id_valid) begin
            upd_sel = UPD_CAPTURE;
        end
    end

    // Upstream holds only for a bubble that really goes in; the freeze is signalled by mem_busy itself.
    always_comb begin
        stall = (upd_sel == UPD_HAZARD);
    end

    // Next contents of the pipeline register and the saturating load-use bubble count.
    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        unique case (upd_sel)
            UPD_HOLD:    ex_d = ex_q;
            UPD_CAPTURE: ex_d = id_rec;
            UPD_HAZARD: begin
                ex_d = bubble();
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default:     ex_d = bubble();
        endcase
    end

    // State registers; reset clears everything so no stall survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= bubble();
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    // Unpack the record onto the execute-stage ports.
    always_comb begin
        ex_valid     = ex_q.valid;
        ex_opcode    = ex_q.opcode;
        ex_alu_on    = ex_q.alu_on;
        ex_mem_read  = ex_q.mem_read;
        ex_mem_write = ex_q.mem_write;
        ex_reg_write = ex_q.reg_write;
        ex_set_flags = ex_q.set_flags;
        ex_rn        = ex_q.rn;
        ex_rm        = ex_q.rm;
        ex_rd        = ex_q.rd;
        ex_a         = ex_q.a;
        ex_b         = ex_q.b;
        ex_imm       = ex_q.imm;
        bubble_cnt   = cnt_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: an instruction-level model checked every cycle plus literal spot checks.
// Latency: model expects ID contents on ex_* one clock after capture.
// Backpressure: exercises stall, mem_busy freeze and flush override.
module tb_id_ex_stage;

    localparam int DW   = 64;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] ADDS = 11'b10101011000;
    localparam logic [10:0] SUBS = 11'b11101011000;
    localparam logic [10:0] ADDI = 11'b10010001000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [10:0]   id_opcode = '0;
    logic          id_alu_on = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
    logic          id_reg_write = 1'b0, id_set_flags = 1'b0;
    logic [4:0]    id_rn = '0, id_rm = '0, id_rd = '0;
    logic          id_rn_used = 1'b0, id_rm_used = 1'b0;
    logic [DW-1:0] id_a = '0, id_b = '0, id_imm = '0;
    logic          flush = 1'b0, mem_busy = 1'b0;

    logic          ex_valid, ex_alu_on, ex_mem_read, ex_mem_write, ex_reg_write, ex_set_flags;
    logic [10:0]   ex_opcode;
    logic [4:0]    ex_rn, ex_rm, ex_rd;
    logic [DW-1:0] ex_a, ex_b, ex_imm;
    logic          stall;
    logic [CW-1:0] bubble_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_alu_on(id_alu_on),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .id_set_flags(id_set_flags), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
        .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
        .flush(flush), .mem_busy(mem_busy),
        .ex_valid(ex_valid), .ex_alu_on(ex_alu_on), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_set_flags(ex_set_flags),
        .ex_opcode(ex_opcode), .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .stall(stall), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // What EX is expected to hold, as an instruction record.
    typedef struct packed {
        logic          v;
        logic [10:0]   op;
        logic          alu, mr, mw, rw, sf;
        logic [4:0]    rn, rm, rd;
        logic [DW-1:0] a, b, imm;
    } instr_t;

    instr_t m_ex  = '0;
    int     m_cnt = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ID must wait when the instruction ahead is a load into a real register that ID reads.
    function automatic bit model_must_wait();
        bit load_ahead;
        bit reads_it;
        load_ahead = m_ex.v && m_ex.mr && m_ex.rw && (m_ex.rd != 5'd31);
        reads_it   = (id_rn_used && id_rn == m_ex.rd) || (id_rm_used && id_rm == m_ex.rd);
        return load_ahead && id_valid && reads_it;
    endfunction

    function automatic instr_t id_as_instr();
        instr_t r;
        r = '{v: 1'b1, op: id_opcode, alu: id_alu_on, mr: id_mem_read, mw: id_mem_write,
              rw: id_reg_write, sf: id_set_flags, rn: id_rn, rm: id_rm, rd: id_rd,
              a: id_a, b: id_b, imm: id_imm};
        return r;
    endfunction

    // Instruction-level model of what moves into EX each clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex  = '0;
            m_cnt = 0;
        end else if (flush) begin
            m_ex = '0;
        end else if (mem_busy) begin
            m_ex = m_ex;
        end else if (model_must_wait()) begin
            m_ex  = '0;
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end else begin
            m_ex = id_valid ? id_as_instr() : '0;
        end
    end

    // Compare DUT against the model on every falling edge outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ex_fields",
                256'({ex_valid, ex_opcode, ex_alu_on, ex_mem_read, ex_mem_write, ex_reg_write,
                      ex_set_flags, ex_rn, ex_rm, ex_rd, ex_a, ex_b, ex_imm}),
                256'(m_ex));
            chk("stall", 256'(stall), 256'(model_must_wait() && !flush && !mem_busy));
            chk("bubble_cnt", 256'(bubble_cnt), 256'(m_cnt));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [10:0] op, input logic alu, input logic mr,
                       input logic rw, input logic sf, input logic [4:0] rn, input logic [4:0] rm,
                       input logic [4:0] rd, input logic rnu, input logic rmu, input logic [63:0] imm);
        id_valid = v;     id_opcode = op;   id_alu_on = alu;  id_mem_read = mr;
        id_mem_write = 1'b0; id_reg_write = rw; id_set_flags = sf;
        id_rn = rn;       id_rm = rm;       id_rd = rd;
        id_rn_used = rnu; id_rm_used = rmu;
        id_a = 64'h0123_4567_89AB_CDEF ^ {59'd0, rn};
        id_b = 64'hFEDC_BA98_7654_3210 ^ {59'd0, rm};
        id_imm = imm;
    endtask

    task automatic ldur(input logic [4:0] rd, input logic [4:0] rn);
        put(1'b1, LDUR, 1'b1, 1'b1, 1'b1, 1'b0, rn, 5'd0, rd, 1'b1, 1'b0, 64'd8);
    endtask
    task automatic adds(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        put(1'b1, ADDS, 1'b1, 1'b0, 1'b1, 1'b1, rn, rm, rd, 1'b1, 1'b1, 64'd0);
    endtask
    task automatic subs(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        put(1'b1, SUBS, 1'b1, 1'b0, 1'b1, 1'b1, rn, rm, rd, 1'b1, 1'b1, 64'd0);
    endtask
    task automatic addi(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        put(1'b1, ADDI, 1'b1, 1'b0, 1'b1, 1'b0, rn, rm, rd, 1'b1, 1'b0, 64'd100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12 rst_n = 1'b1;
        #1;
        chk("reset_valid", 256'(ex_valid), 256'(0));
        chk("reset_cnt", 256'(bubble_cnt), 256'(0));

        // Load-use: LDUR X1 then ADDS reading X1 costs one bubble, then ADDS advances.
        ldur(5'd1, 5'd2);
        cyc();
        adds(5'd3, 5'd1, 5'd4);
        #1 chk("lu_stall", 256'(stall), 256'(1));
        cyc();
        chk("lu_bubble", 256'(ex_valid), 256'(0));
        chk("lu_stall_drop", 256'(stall), 256'(0));
        chk("lu_cnt", 256'(bubble_cnt), 256'(1));
        cyc();
        chk("lu_adds_in", 256'({ex_valid, ex_opcode, ex_rd}), 256'({1'b1, ADDS, 5'd3}));
        // Dependent SUBS after ADDS is forwarded, not stalled.
        subs(5'd5, 5'd3, 5'd3);
        #1 chk("alu_dep_nostall", 256'(stall), 256'(0));
        cyc();

        // XZR destination and unused rm never hazard.
        ldur(5'd31, 5'd2);
        cyc();
        adds(5'd6, 5'd31, 5'd31);
        #1 chk("xzr_nostall", 256'(stall), 256'(0));
        cyc();
        ldur(5'd1, 5'd2);
        cyc();
        addi(5'd6, 5'd2, 5'd1);
        #1 chk("rm_unused_nostall", 256'(stall), 256'(0));
        cyc();

        // X30 behaves like any register.
        ldur(5'd30, 5'd2);
        cyc();
        adds(5'd7, 5'd8, 5'd30);
        #1 chk("x30_stall", 256'(stall), 256'(1));
        cyc();
        cyc();
        chk("x30_cnt", 256'(bubble_cnt), 256'(2));

        // Invalid ID loads an uncounted bubble.
        put(1'b0, SUBS, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 64'd5);
        cyc();
        chk("idle_bubble", 256'({ex_valid, ex_opcode, ex_rd}), 256'(0));

        // Freeze: SUBS in EX held for three mem_busy cycles, ADDI enters afterwards.
        subs(5'd9, 5'd10, 5'd11);
        cyc();
        addi(5'd12, 5'd9, 5'd0);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("freeze_hold", 256'({ex_opcode, ex_rd}), 256'({SUBS, 5'd9}));
        end
        mem_busy = 1'b0;
        cyc();
        chk("freeze_release", 256'({ex_opcode, ex_rd}), 256'({ADDI, 5'd12}));

        // Flush beats a hazard: no stall, bubble, not counted; also with mem_busy.
        ldur(5'd2, 5'd3);
        cyc();
        adds(5'd4, 5'd2, 5'd0);
        flush = 1'b1;
        #1 chk("flush_nostall", 256'(stall), 256'(0));
        cyc();
        chk("flush_bubble", 256'({ex_valid, bubble_cnt}), 256'({1'b0, 2'd2}));
        flush = 1'b0;
        ldur(5'd2, 5'd3);
        cyc();
        adds(5'd4, 5'd2, 5'd0);
        flush = 1'b1;
        mem_busy = 1'b1;
        cyc();
        chk("flush_busy_bubble", 256'({ex_valid, bubble_cnt}), 256'({1'b0, 2'd2}));
        flush = 1'b0;
        mem_busy = 1'b0;

        // Hazard pending under mem_busy is re-evaluated once the freeze lifts.
        ldur(5'd4, 5'd5);
        cyc();
        adds(5'd6, 5'd4, 5'd4);
        mem_busy = 1'b1;
        #1 chk("busy_nostall", 256'(stall), 256'(0));
        cyc();
        mem_busy = 1'b0;
        #1 chk("busy_drop_stall", 256'(stall), 256'(1));
        cyc();
        cyc();

        // Two more load-use stalls: five in total saturate the 2-bit count at 3.
        for (int i = 0; i < 2; i++) begin
            ldur(5'd7, 5'd5);
            cyc();
            adds(5'd8, 5'd9, 5'd7);
            cyc();
            cyc();
        end
        chk("sat_cnt", 256'(bubble_cnt), 256'(3));

        // Reset in the middle of a stall clears outputs at once and forgets the stall.
        ldur(5'd1, 5'd2);
        cyc();
        adds(5'd3, 5'd1, 5'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ex", 256'({ex_valid, ex_opcode, ex_mem_read, ex_reg_write, ex_rd, ex_a}), 256'(0));
        chk("arst_cnt", 256'(bubble_cnt), 256'(0));
        chk("arst_stall", 256'(stall), 256'(0));
        #3 rst_n = 1'b1;
        #1 chk("post_rst_stall", 256'(stall), 256'(0));
        cyc();
        chk("post_rst_adds", 256'({ex_valid, ex_opcode}), 256'({1'b1, ADDS}));
        put(1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
